// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle between the two byte requesters, the bus arbiter and the shared SPI engine.
// The slave modport is the arbiter's view; master is the sequencer/engine side.
interface spi_bus_arbiter_if;
    logic       r0_req;
    logic [7:0] r0_din;
    logic       r0_last;
    logic       r0_grant;
    logic       r0_done;
    logic       r1_req;
    logic [7:0] r1_din;
    logic       r1_last;
    logic       r1_grant;
    logic       r1_done;
    logic [7:0] dout;
    logic [1:0] cs_n;
    logic [1:0] txn_end;
    logic       timeout_err;
    logic       err_sticky;
    logic       eng_send_request;
    logic [7:0] eng_din;
    logic [7:0] eng_dout;
    logic       eng_data_valid;
    logic       eng_processing;

    modport slave (
        input  r0_req, r0_din, r0_last, r1_req, r1_din, r1_last,
               eng_dout, eng_data_valid, eng_processing,
        output r0_grant, r0_done, r1_grant, r1_done, dout, cs_n, txn_end,
               timeout_err, err_sticky, eng_send_request, eng_din
    );

    modport master (
        output r0_req, r0_din, r0_last, r1_req, r1_din, r1_last,
               eng_dout, eng_data_valid, eng_processing,
        input  r0_grant, r0_done, r1_grant, r1_done, dout, cs_n, txn_end,
               timeout_err, err_sticky, eng_send_request, eng_din
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between two requesters, with chip-select
// setup/gap timing, multi-byte bus locking and a stall watchdog.
module spi_bus_arbiter #(
    parameter int CS_SETUP   = 1,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input logic              clk,
    input logic              reset,
    spi_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, DONE, HOLD, ABORT, GAP} state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic       owner;
    logic       last_owner;
    logic       lat_last;
    logic [7:0] timer;
    logic [7:0] cnt;
    logic       dv_p0;

    logic       own_req;
    logic [7:0] own_din;
    logic       own_last;
    logic       arb_any;
    logic       arb_pick;
    logic       setup_end;
    logic       gap_end;
    logic       launch;
    logic       take;
    logic       dv_rise;
    logic       timed_out;

    // The launch fires on the last setup cycle so cs_n leads send_request by exactly CS_SETUP;
    // the final gap cycle arbitrates directly so a waiting requester sees exactly GAP_CYCLES.
    always_comb begin
        own_req   = owner ? bus.r1_req  : bus.r0_req;
        own_din   = owner ? bus.r1_din  : bus.r0_din;
        own_last  = owner ? bus.r1_last : bus.r0_last;
        arb_any   = bus.r0_req | bus.r1_req;
        arb_pick  = (bus.r0_req & bus.r1_req) ? ~last_owner : bus.r1_req;
        setup_end = (state == SETUP) && (cnt == SETUP_LAST);
        gap_end   = (state == GAP) && (cnt == GAP_LAST);
        launch    = ((state == START) || setup_end) && !bus.eng_processing;
        take      = ((state == IDLE) || gap_end) && arb_any;
        dv_rise   = bus.eng_data_valid & ~dv_p0;
        timed_out = (((state == WAIT) && !dv_rise) || ((state == HOLD) && !own_req)) &&
                    (timer == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        dv_p0 <= bus.eng_data_valid;
        if (reset) begin
            state                <= IDLE;
            owner                <= 1'b0;
            last_owner           <= 1'b1;
            lat_last             <= 1'b0;
            timer                <= 8'd0;
            cnt                  <= 8'd0;
            bus.r0_grant         <= 1'b0;
            bus.r1_grant         <= 1'b0;
            bus.r0_done          <= 1'b0;
            bus.r1_done          <= 1'b0;
            bus.cs_n             <= 2'b11;
            bus.txn_end          <= 2'b00;
            bus.timeout_err      <= 1'b0;
            bus.err_sticky       <= 1'b0;
            bus.eng_send_request <= 1'b0;
            bus.eng_din          <= 8'd0;
            bus.dout             <= 8'd0;
        end else begin
            bus.eng_send_request <= 1'b0;
            bus.r0_done          <= 1'b0;
            bus.r1_done          <= 1'b0;
            bus.txn_end          <= 2'b00;
            bus.timeout_err      <= 1'b0;
            if (launch) begin
                bus.eng_din          <= own_din;
                lat_last             <= own_last;
                bus.eng_send_request <= 1'b1;
                timer                <= 8'd0;
                state                <= WAIT;
            end else if (take) begin
                owner        <= arb_pick;
                bus.r0_grant <= ~arb_pick;
                bus.r1_grant <= arb_pick;
                bus.cs_n     <= arb_pick ? 2'b01 : 2'b10;
                cnt          <= 8'd0;
                state        <= (CS_SETUP == 0) ? START : SETUP;
            end else if (timed_out) begin
                bus.cs_n        <= 2'b11;
                bus.r0_grant    <= 1'b0;
                bus.r1_grant    <= 1'b0;
                bus.timeout_err <= 1'b1;
                bus.err_sticky  <= 1'b1;
                last_owner      <= owner;
                state           <= ABORT;
            end else begin
                case (state)
                    IDLE:  ;
                    SETUP: begin
                        if (setup_end) state <= START;
                        else           cnt   <= cnt + 8'd1;
                    end
                    START: ;
                    WAIT: begin
                        if (dv_rise) begin
                            bus.dout    <= bus.eng_dout;
                            bus.r0_done <= ~owner;
                            bus.r1_done <= owner;
                            bus.txn_end <= lat_last ? {owner, ~owner} : 2'b00;
                            state       <= DONE;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                    DONE: begin
                        if (lat_last) begin
                            bus.cs_n     <= 2'b11;
                            bus.r0_grant <= 1'b0;
                            bus.r1_grant <= 1'b0;
                            last_owner   <= owner;
                            cnt          <= 8'd0;
                            state        <= GAP;
                        end else begin
                            timer <= 8'd0;
                            state <= HOLD;
                        end
                    end
                    // The other requester is deliberately ignored while the owner holds the bus.
                    HOLD: begin
                        if (own_req) state <= START;
                        else         timer <= timer + 8'd1;
                    end
                    ABORT: begin
                        cnt   <= 8'd0;
                        state <= GAP;
                    end
                    GAP: begin
                        if (gap_end) state <= IDLE;
                        else         cnt   <= cnt + 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: table-driven arbitration vectors, a requester/engine model with a
// response scoreboard, and hand-written sequences for locking, gap, stall, busy-engine and reset.
module tb_spi_bus_arbiter;
    localparam int GAP_CYCLES = 2;

    typedef struct packed {
        logic [7:0] din;
        logic       last;
    } tx_t;

    typedef struct packed {
        logic r0;
        logic r1;
        logic first;
    } arb_vec_t;

    logic clk;
    logic reset;
    spi_bus_arbiter_if bus();

    spi_bus_arbiter #(.CS_SETUP(1), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         n_send = 0;
    int         n_done0 = 0;
    int         n_done1 = 0;
    int         t_done = 0;
    int         inv_bad = 0;
    int         eng_lat = 3;
    int         eng_cnt = 0;
    logic       eng_hang = 1'b0;
    logic [7:0] eng_resp = 8'h00;
    logic       outstanding = 1'b0;
    logic       g0_prev = 1'b0;
    logic       g1_prev = 1'b0;
    tx_t        tx0[$];
    tx_t        tx1[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic       grant_log[$];
    arb_vec_t   vecs[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic fail_now(input string nm, input string what);
        total_cnt++;
        $display("FAIL %s: actual=%s required=expected event", nm, what);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic present();
        bus.r0_req  = (tx0.size() != 0);
        bus.r0_din  = (tx0.size() != 0) ? tx0[0].din : 8'h00;
        bus.r0_last = (tx0.size() != 0) ? tx0[0].last : 1'b0;
        bus.r1_req  = (tx1.size() != 0);
        bus.r1_din  = (tx1.size() != 0) ? tx1[0].din : 8'h00;
        bus.r1_last = (tx1.size() != 0) ? tx1[0].last : 1'b0;
    endtask

    task automatic enq(input logic r, input logic [7:0] d, input logic l);
        tx_t t;
        t.din  = d;
        t.last = l;
        if (r) begin
            tx1.push_back(t);
            exp1.push_back(d ^ 8'h5A);
        end else begin
            tx0.push_back(t);
            exp0.push_back(d ^ 8'h5A);
        end
        present();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((tx0.size() != 0 || tx1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) fail_now("wait_idle", "queues not drained");
        repeat (GAP_CYCLES + 2) tick();
    endtask

    task automatic wait_send(input int budget);
        int n;
        int s0;
        n  = 0;
        s0 = n_send;
        while (n_send == s0 && n < budget) begin
            tick();
            n++;
        end
        if (n_send == s0) fail_now("wait_send", "no send_request");
    endtask

    // Requester and engine model plus scoreboard, evaluated once per cycle away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if ((bus.r0_grant && bus.r1_grant) || bus.cs_n == 2'b00 ||
                    (!bus.cs_n[0] && !bus.r0_grant) || (!bus.cs_n[1] && !bus.r1_grant))
                    inv_bad++;
                if (bus.r0_grant && !g0_prev) grant_log.push_back(1'b0);
                if (bus.r1_grant && !g1_prev) grant_log.push_back(1'b1);
                if (bus.r0_done && bus.r1_done) inv_bad++;
                if (bus.r0_done || bus.r1_done) begin
                    if (!outstanding) inv_bad++;
                    outstanding = 1'b0;
                    t_done = cyc;
                end
                if (bus.r0_done) begin
                    if (tx0.size() == 0) fail_now("done_r0", "unrequested done");
                    else begin
                        check("dout_r0", bus.dout, exp0.pop_front());
                        check("txn_end_r0", bus.txn_end, tx0[0].last ? 2'b01 : 2'b00);
                        tx0.delete(0);
                        n_done0++;
                        present();
                    end
                end
                if (bus.r1_done) begin
                    if (tx1.size() == 0) fail_now("done_r1", "unrequested done");
                    else begin
                        check("dout_r1", bus.dout, exp1.pop_front());
                        check("txn_end_r1", bus.txn_end, tx1[0].last ? 2'b10 : 2'b00);
                        tx1.delete(0);
                        n_done1++;
                        present();
                    end
                end
                if (bus.timeout_err) outstanding = 1'b0;
                if (bus.eng_send_request) begin
                    n_send++;
                    outstanding = 1'b1;
                    if (bus.r1_grant && tx1.size() != 0)      check("eng_din_r1", bus.eng_din, tx1[0].din);
                    else if (bus.r0_grant && tx0.size() != 0) check("eng_din_r0", bus.eng_din, tx0[0].din);
                    else fail_now("send_owner", "send without requesting owner");
                    bus.eng_data_valid = 1'b0;
                    eng_resp = bus.eng_din ^ 8'h5A;
                    eng_cnt  = eng_hang ? 0 : eng_lat;
                end else if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        bus.eng_dout       = eng_resp;
                        bus.eng_data_valid = 1'b1;
                    end
                end
            end
            g0_prev = bus.r0_grant;
            g1_prev = bus.r1_grant;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=time limit required=bench completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        int gl;
        int d0;
        int d1;
        int ts;
        int n;
        int bad;
        int s0;

        vecs[0] = '{r0: 1'b1, r1: 1'b1, first: 1'b0};
        vecs[1] = '{r0: 1'b1, r1: 1'b0, first: 1'b0};
        vecs[2] = '{r0: 1'b1, r1: 1'b1, first: 1'b1};
        vecs[3] = '{r0: 1'b0, r1: 1'b1, first: 1'b1};
        vecs[4] = '{r0: 1'b1, r1: 1'b1, first: 1'b0};

        reset = 1'b1;
        bus.eng_dout = 8'h00;
        bus.eng_data_valid = 1'b0;
        bus.eng_processing = 1'b0;
        present();
        repeat (3) @(posedge clk);
        tick();
        check("rst_grant", {bus.r1_grant, bus.r0_grant}, 2'b00);
        check("rst_cs_n", bus.cs_n, 2'b11);
        check("rst_done", {bus.r1_done, bus.r0_done}, 2'b00);
        check("rst_send", bus.eng_send_request, 1'b0);
        check("rst_err", {bus.err_sticky, bus.timeout_err}, 2'b00);
        reset = 1'b0;
        tick();

        // Arbitration vectors: simultaneous requests from idle alternate by last owner.
        eng_lat = 3;
        for (int i = 0; i < 5; i++) begin
            gl = grant_log.size();
            if (vecs[i].r0) enq(1'b0, 8'h10 + 8'(i), 1'b1);
            if (vecs[i].r1) enq(1'b1, 8'h20 + 8'(i), 1'b1);
            wait_idle(200);
            check("arb_count", grant_log.size(), gl + int'(vecs[i].r0) + int'(vecs[i].r1));
            if (grant_log.size() > gl) check("arb_first", grant_log[gl], vecs[i].first);
            if (vecs[i].r0 && vecs[i].r1 && grant_log.size() > gl + 1)
                check("arb_second", grant_log[gl + 1], !vecs[i].first);
        end

        // Single r0 byte with a 10-cycle engine.
        eng_lat = 10;
        d0 = n_done0;
        enq(1'b0, 8'h9C, 1'b1);
        tick();
        check("t1_grant", {bus.r1_grant, bus.r0_grant}, 2'b01);
        check("t1_cs", bus.cs_n, 2'b10);
        tick();
        check("t1_send", bus.eng_send_request, 1'b1);
        ts = cyc;
        n = 0;
        while (n_done0 == d0 && n < 40) begin
            tick();
            n++;
        end
        if (n_done0 == d0) fail_now("t1_done", "no done");
        else begin
            check("t1_latency", t_done - ts, 11);
            check("t1_txn_end", bus.txn_end, 2'b01);
            check("t1_dout", bus.dout, 8'h9C ^ 8'h5A);
            tick();
            check("t1_cs_release", {bus.cs_n, bus.r0_grant}, 3'b110);
        end
        wait_idle(50);

        // Four-byte r0 transaction locks out a waiting r1.
        eng_lat = 3;
        d0 = n_done0;
        enq(1'b0, 8'h03, 1'b0);
        enq(1'b0, 8'h00, 1'b0);
        enq(1'b0, 8'h00, 1'b0);
        enq(1'b0, 8'hA7, 1'b1);
        tick();
        check("t2_r0_first", {bus.r1_grant, bus.r0_grant}, 2'b01);
        enq(1'b1, 8'h3C, 1'b1);
        bad = 0;
        n = 0;
        while (n_done0 < d0 + 4 && n < 200) begin
            tick();
            n++;
            if (bus.cs_n[0] || !bus.r0_grant || bus.r1_grant) bad++;
        end
        if (n_done0 < d0 + 4) fail_now("t2_bytes", "fewer than 4 done");
        check("t2_lock", bad, 0);
        tick();
        check("t2_gap1", bus.cs_n, 2'b11);
        tick();
        check("t2_gap2", bus.cs_n, 2'b11);
        tick();
        check("t2_r1_grant", {bus.r1_grant, bus.cs_n}, 3'b101);
        wait_idle(100);

        // Busy engine delays the start pulse.
        bus.eng_processing = 1'b1;
        enq(1'b1, 8'h55, 1'b1);
        tick();
        check("t3_grant", bus.r1_grant, 1'b1);
        bad = 0;
        s0 = n_send;
        repeat (5) begin
            tick();
            if (bus.eng_send_request) bad++;
        end
        check("t3_held", bad + (n_send - s0), 0);
        bus.eng_processing = 1'b0;
        tick();
        check("t3_send", bus.eng_send_request, 1'b1);
        tick();
        check("t3_width", bus.eng_send_request, 1'b0);
        wait_idle(100);

        // Stalled engine triggers the watchdog 255 cycles after the send.
        eng_hang = 1'b1;
        enq(1'b0, 8'h66, 1'b1);
        wait_send(10);
        ts = cyc;
        d0 = n_done0;
        n = 0;
        while (!bus.timeout_err && n < 300) begin
            tick();
            n++;
        end
        if (!bus.timeout_err) fail_now("t4_abort", "no timeout_err");
        else begin
            check("t4_abort_time", cyc - ts, 255);
            check("t4_sticky", bus.err_sticky, 1'b1);
            check("t4_cs_grant", {bus.cs_n, bus.r1_grant, bus.r0_grant}, 4'b1100);
            check("t4_no_done", n_done0 - d0, 0);
            check("t4_no_txn_end", bus.txn_end, 2'b00);
        end
        tx0.delete();
        exp0.delete();
        present();
        eng_hang = 1'b0;
        tick();
        check("t4_pulse", {bus.err_sticky, bus.timeout_err}, 2'b10);
        wait_idle(50);

        // Reset in the middle of an r1 byte.
        eng_lat = 40;
        enq(1'b1, 8'h81, 1'b1);
        wait_send(10);
        repeat (3) tick();
        reset = 1'b1;
        tx1.delete();
        exp1.delete();
        present();
        eng_cnt = 0;
        bus.eng_data_valid = 1'b0;
        outstanding = 1'b0;
        tick();
        check("t5_grant", {bus.r1_grant, bus.r0_grant}, 2'b00);
        check("t5_cs_n", bus.cs_n, 2'b11);
        check("t5_done", {bus.r1_done, bus.r0_done, bus.txn_end}, 4'b0000);
        check("t5_err", {bus.err_sticky, bus.timeout_err}, 2'b00);
        check("t5_eng", {bus.eng_send_request, bus.eng_din}, 9'h000);
        check("t5_dout", bus.dout, 8'h00);
        reset = 1'b0;
        eng_lat = 3;
        tick();
        d1 = n_done1;
        enq(1'b1, 8'hE4, 1'b1);
        n = 0;
        while (n_done1 == d1 && n < 50) begin
            tick();
            n++;
        end
        check("t5_served", n_done1 - d1, 1);
        wait_idle(50);

        check("invariants", inv_bad, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
